sdram_wb_bridge: RTL and testbench
==================================

SDRAM_WB_BRIDGE -- requirements
Module: sdram_wb_bridge

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h3800_0000, meaning the SDRAM window base; decode compares bits [31:23] only.
REQ-002 SHALL have parameter WFIFO_DEPTH, default 4, meaning the posted-write FIFO entries (power of 2, 2..8).
REQ-003 SHALL have parameter RD_TIMEOUT, default 255, meaning the maximum cycles to wait for read data.
REQ-004 SHALL have one clock and reset: reset is asynchronous and active-high; ports: clk in 1 (rising edge); rst in 1 (async, active-high).
REQ-005 SHALL have Wishbone slave inputs: wb_cyc_i in 1; wb_stb_i in 1; wb_we_i in 1; wb_sel_i in 4 (ignored, full-word only); wb_adr_i in 32 (byte address); wb_dat_i in 32 (write data).
REQ-006 SHALL have Wishbone slave outputs: wb_ack_o out 1; wb_dat_o out 32 (read data).
REQ-007 SHALL have controller-side ports: ctrl_addr out 23 (byte address = wb_adr_i[22:0]); ctrl_rw out 1 (1=write); ctrl_wdata out 32; ctrl_in_valid out 1 (request pulse); ctrl_busy in 1; ctrl_rdata in 32; ctrl_out_valid in 1.
REQ-008 SHALL have status outputs: wr_pending out 1 (FIFO non-empty or write in flight); rd_err out 1 (sticky read-timeout flag).

Function
REQ-009 SHALL treat a request as valid when wb_cyc_i & wb_stb_i & !wb_ack_o & (wb_adr_i[31:23]==BASE_ADDR[31:23]); it SHALL never acknowledge non-matching addresses.
REQ-010 SHALL register all outputs; wb_ack_o SHALL be a single-cycle pulse per accepted transaction.
REQ-011 Write: when valid, wb_we_i=1 and FIFO not full at cycle start, SHALL push {adr[22:0], dat} and assert wb_ack_o the next cycle; a full FIFO stalls (no ack) even if a pop occurs in the same cycle.
REQ-012 Simultaneous push and pop SHALL leave the count unchanged; pointers SHALL wrap modulo WFIFO_DEPTH.
REQ-013 FSM states SHALL be IDLE, HOLD, RD_WAIT, RD_ACK.
REQ-014 IDLE: if FIFO non-empty and ctrl_busy=0, SHALL pop the head, drive ctrl_rw=1, ctrl_addr and ctrl_wdata, pulse ctrl_in_valid for one cycle, and go to HOLD.
REQ-015 IDLE: else if a valid read is present, FIFO empty and ctrl_busy=0, SHALL drive ctrl_rw=0 and ctrl_addr, pulse ctrl_in_valid for one cycle, and go to HOLD with a read-pending mark; writes already in the FIFO are always issued before a later read (no read bypass).
REQ-016 HOLD: SHALL last exactly one cycle, ignoring ctrl_busy (covers the controller's one-cycle busy-assert latency); next state is RD_WAIT if a read is pending, else IDLE.
REQ-017 RD_WAIT: on ctrl_out_valid=1, SHALL load wb_dat_o<=ctrl_rdata and go to RD_ACK.
REQ-018 RD_WAIT: a timeout counter SHALL reach RD_TIMEOUT cycles without ctrl_out_valid, then wb_dat_o<=32'hDEAD_BEEF, rd_err<=1, and go to RD_ACK.
REQ-019 RD_ACK: SHALL assert wb_ack_o for one cycle, then go to IDLE.
REQ-020 ctrl_out_valid outside RD_WAIT SHALL be ignored (covers controller-initiated prefetch reads and stale responses).
REQ-021 If wb_cyc_i drops while in RD_WAIT, the SHALL still complete the read but suppress wb_ack_o in RD_ACK.
REQ-022 Write acks SHALL not depend on FSM state; write-ack and read-ack cannot coincide, because reads are accepted only with an empty FIFO.
REQ-023 wr_pending SHALL be 1 when FIFO count>0 or the FSM is in HOLD with a write issued.

Reset
REQ-024 On rst=1 (asynchronous), SHALL clear: wb_ack_o=0, wb_dat_o=0, ctrl_in_valid=0, ctrl_rw=0, ctrl_addr=0, ctrl_wdata=0, rd_err=0, wr_pending=0, FIFO empty, timeout counter 0, state IDLE.
REQ-025 Reset mid-transaction SHALL drop any outstanding read or buffered writes without ack; after release, the first accepted request SHALL behave as from cold reset.
REQ-026 rd_err SHALL clear only on reset.

Verification
REQ-027 Single write 0x3800_0010 / 0x1234_5678, busy=0 -> ack at cycle+1; ctrl_in_valid pulse with ctrl_rw=1, ctrl_addr=23'h10, ctrl_wdata=0x1234_5678.
REQ-028 Five back-to-back writes with ctrl_busy held 1 -> first four acked on consecutive accepts, fifth stalls until a pop; issue order preserved after busy drops.
REQ-029 Two writes queued, then read 0x3800_0010 -> read stalls until both writes are issued; ctrl_rdata=0xCAFE_F00D with out_valid 4 cycles after the read pulse -> wb_dat_o=0xCAFE_F00D, one-cycle ack.
REQ-030 Read with no ctrl_out_valid -> ack after RD_TIMEOUT cycles with wb_dat_o=0xDEAD_BEEF and rd_err=1 (sticky).
REQ-031 Unsolicited ctrl_out_valid in IDLE, plus access to 0x3000_0000 -> no ack and no ctrl_in_valid; assert rst in RD_WAIT -> all outputs zero immediately, no ack.

Source files
------------

// File: rtl/sdram_wb_bridge.sv
// sdram_wb_bridge
//   Wishbone slave to SDRAM controller bridge. Writes are posted into a
//   small FIFO and acknowledged immediately. Reads are issued only once
//   the FIFO has drained, and are acknowledged when the controller returns
//   data or when the read timeout expires.
//
// Ports
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   wb_*_i / wb_*_o   Wishbone slave (full-word only, wb_sel_i ignored)
//   ctrl_addr/rw/     request to the controller; ctrl_in_valid is a
//   wdata/in_valid      one-cycle pulse
//   ctrl_busy         controller cannot accept a request
//   ctrl_rdata/       read data return
//   ctrl_out_valid
//   wr_pending        FIFO non-empty or a write is being handed over
//   rd_err            sticky read-timeout flag, cleared only by reset
module sdram_wb_bridge #(
  parameter logic [31:0] BASE_ADDR   = 32'h3800_0000,
  parameter int unsigned WFIFO_DEPTH = 4,
  parameter int unsigned RD_TIMEOUT  = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [3:0]  wb_sel_i,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  output logic        wb_ack_o,
  output logic [31:0] wb_dat_o,
  output logic [22:0] ctrl_addr,
  output logic        ctrl_rw,
  output logic [31:0] ctrl_wdata,
  output logic        ctrl_in_valid,
  input  logic        ctrl_busy,
  input  logic [31:0] ctrl_rdata,
  input  logic        ctrl_out_valid,
  output logic        wr_pending,
  output logic        rd_err
);

  localparam int unsigned PW = $clog2(WFIFO_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned TW = $clog2(RD_TIMEOUT + 1);
  localparam logic [TW-1:0] T_LAST = TW'(RD_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, HOLD, RD_WAIT, RD_ACK} state_t;

  state_t        state, state_nx;
  logic [54:0]   mem [WFIFO_DEPTH];
  logic [PW-1:0] wptr, rptr;
  logic [CW-1:0] count, count_nx;
  logic [TW-1:0] tcnt;
  logic          rd_pend, rd_abort;
  logic          req_valid, full, empty, push, pop, issue_rd, rd_load, rd_tout;
  logic [54:0]   head;
  logic          unused_sel;

  assign unused_sel = &wb_sel_i;

  // !wb_ack_o keeps a still-asserted strobe from being taken twice
  assign req_valid = wb_cyc_i & wb_stb_i & ~wb_ack_o &
                     (wb_adr_i[31:23] == BASE_ADDR[31:23]);
  assign full      = (count == CW'(WFIFO_DEPTH));
  assign empty     = (count == '0);
  // fullness is judged at cycle start, so a same-cycle pop does not help
  assign push      = req_valid & wb_we_i & ~full;
  assign head      = mem[rptr];
  assign count_nx  = count + CW'(push) - CW'(pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    pop      = 1'b0;
    issue_rd = 1'b0;
    rd_load  = 1'b0;
    rd_tout  = 1'b0;
    case (state)
      IDLE: begin
        if (!empty && !ctrl_busy) begin
          pop      = 1'b1;
          state_nx = HOLD;
        end else if (req_valid && !wb_we_i && empty && !ctrl_busy) begin
          issue_rd = 1'b1;
          state_nx = HOLD;
        end
      end
      // one dead cycle while the controller raises busy
      HOLD:    state_nx = rd_pend ? RD_WAIT : IDLE;
      RD_WAIT: begin
        if (ctrl_out_valid) begin
          rd_load  = 1'b1;
          state_nx = RD_ACK;
        end else if (tcnt == T_LAST) begin
          rd_tout  = 1'b1;
          state_nx = RD_ACK;
        end
      end
      RD_ACK:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= {wb_adr_i[22:0], wb_dat_i};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_ack_o      <= 1'b0;
      wb_dat_o      <= '0;
      ctrl_addr     <= '0;
      ctrl_rw       <= 1'b0;
      ctrl_wdata    <= '0;
      ctrl_in_valid <= 1'b0;
      wr_pending    <= 1'b0;
      rd_err        <= 1'b0;
      wptr          <= '0;
      rptr          <= '0;
      count         <= '0;
      tcnt          <= '0;
      rd_pend       <= 1'b0;
      rd_abort      <= 1'b0;
    end else begin
      wb_ack_o      <= push | ((state == RD_ACK) & wb_cyc_i & ~rd_abort);
      ctrl_in_valid <= pop | issue_rd;
      if (pop) begin
        ctrl_rw    <= 1'b1;
        ctrl_addr  <= head[54:32];
        ctrl_wdata <= head[31:0];
      end else if (issue_rd) begin
        ctrl_rw   <= 1'b0;
        ctrl_addr <= wb_adr_i[22:0];
      end
      if (state == IDLE) rd_pend <= issue_rd;
      if (state == RD_WAIT) tcnt <= tcnt + TW'(1);
      else                  tcnt <= '0;
      if (state == HOLD)                     rd_abort <= 1'b0;
      else if (state == RD_WAIT && !wb_cyc_i) rd_abort <= 1'b1;
      if (rd_load) wb_dat_o <= ctrl_rdata;
      if (rd_tout) begin
        wb_dat_o <= 32'hDEAD_BEEF;
        rd_err   <= 1'b1;
      end
      if (push) wptr <= wptr + PW'(1);
      if (pop)  rptr <= rptr + PW'(1);
      count      <= count_nx;
      wr_pending <= (count_nx != '0) | pop;
    end
  end

endmodule

// File: tb/tb_sdram_wb_bridge.sv
// tb_sdram_wb_bridge
//   Randomised bench for sdram_wb_bridge with a transaction-level model:
//   an ordered queue of expected controller requests, FIFO occupancy from
//   accept/issue counts, and read-ack timing from the response latency.
module tb_sdram_wb_bridge;

  localparam int T = 16;
  localparam int D = 4;
  localparam logic [31:0] BASE = 32'h3800_0000;
  localparam int NEVER = 32'h7fff_ffff;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_cyc_i, wb_stb_i, wb_we_i;
  logic [3:0]  wb_sel_i;
  logic [31:0] wb_adr_i, wb_dat_i;
  logic        wb_ack_o;
  logic [31:0] wb_dat_o;
  logic [22:0] ctrl_addr;
  logic        ctrl_rw;
  logic [31:0] ctrl_wdata;
  logic        ctrl_in_valid;
  logic        ctrl_busy;
  logic [31:0] ctrl_rdata;
  logic        ctrl_out_valid;
  logic        wr_pending, rd_err;

  sdram_wb_bridge #(.BASE_ADDR(BASE), .WFIFO_DEPTH(D), .RD_TIMEOUT(T)) dut (
    .clk(clk), .rst(rst),
    .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i),
    .wb_sel_i(wb_sel_i), .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i),
    .wb_ack_o(wb_ack_o), .wb_dat_o(wb_dat_o),
    .ctrl_addr(ctrl_addr), .ctrl_rw(ctrl_rw), .ctrl_wdata(ctrl_wdata),
    .ctrl_in_valid(ctrl_in_valid), .ctrl_busy(ctrl_busy),
    .ctrl_rdata(ctrl_rdata), .ctrl_out_valid(ctrl_out_valid),
    .wr_pending(wr_pending), .rd_err(rd_err)
  );

  always #5 clk = ~clk;

  int cyc_n = 0;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc_n);
    end
  endtask

  // ---------------- stimulus knobs ----------------
  int          busy_mode = 0;   // 0 idle, 1 always busy, 2 random
  bit          noise_en  = 0;   // unsolicited ctrl_out_valid when no read is out
  int          rd_lat    = 1;   // response delay after the read pulse, 0 = none
  logic [31:0] rd_val    = '0;

  // ---------------- reference model ----------------
  typedef struct {
    bit          rw;
    logic [22:0] addr;
    logic [31:0] data;
  } req_t;

  req_t        exp_q[$];
  int          acc_cnt, wpulse_cnt;
  bit          acc_prev, exp_ack;
  bit          rd_logged, rd_active, rd_abort;
  int          rd_p, rd_ack_c, err_from;
  logic [31:0] rd_exp_data;
  bit          prev_pulse, prev_busy;
  int          last_pulse_c;

  always @(negedge clk) begin : cmp
    bit   rack, valid;
    req_t e;
    int   l;
    if (rst) begin
      exp_q.delete();
      acc_cnt = 0; wpulse_cnt = 0; acc_prev = 0; exp_ack = 0;
      rd_logged = 0; rd_active = 0; rd_abort = 0; err_from = NEVER;
      prev_pulse = 0; prev_busy = ctrl_busy;
    end else begin
      rack    = rd_active && (cyc_n == rd_ack_c) && !rd_abort;
      exp_ack = acc_prev || rack;
      chk("wb_ack_o", wb_ack_o, exp_ack);
      if (rack) chk("wb_dat_o at read ack", wb_dat_o, rd_exp_data);
      if (rd_active && cyc_n == rd_ack_c) begin
        rd_active = 0;
        rd_logged = 0;
      end
      if (rd_active && cyc_n > rd_p && !wb_cyc_i) rd_abort = 1;
      chk("wr_pending", wr_pending, acc_cnt > wpulse_cnt);
      chk("rd_err", rd_err, cyc_n >= err_from);
      if (ctrl_in_valid) begin
        chk("request pulse right after another", prev_pulse, 0);
        chk("request issued while busy", prev_busy, 0);
        if (exp_q.size() == 0) begin
          chk("unexpected ctrl request", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("ctrl_rw", ctrl_rw, e.rw);
          chk("ctrl_addr", ctrl_addr, e.addr);
          if (e.rw) begin
            chk("ctrl_wdata", ctrl_wdata, e.data);
            wpulse_cnt++;
          end else begin
            rd_active = 1;
            rd_abort  = 0;
            rd_p      = cyc_n;
            l         = rd_lat;
            if (l >= 1 && l <= T) begin
              rd_ack_c    = cyc_n + l + 2;
              rd_exp_data = rd_val;
            end else begin
              rd_ack_c    = cyc_n + T + 2;
              rd_exp_data = 32'hDEAD_BEEF;
              if (err_from == NEVER) err_from = cyc_n + T + 1;
            end
          end
        end
        last_pulse_c = cyc_n;
      end
      valid = wb_cyc_i && wb_stb_i && !exp_ack && (wb_adr_i[31:23] == BASE[31:23]);
      acc_prev = valid && wb_we_i && ((acc_cnt - wpulse_cnt) < D);
      if (acc_prev) begin
        acc_cnt++;
        exp_q.push_back('{rw: 1'b1, addr: wb_adr_i[22:0], data: wb_dat_i});
      end
      if (valid && !wb_we_i && !rd_logged) begin
        exp_q.push_back('{rw: 1'b0, addr: wb_adr_i[22:0], data: 32'h0});
        rd_logged = 1;
      end
      prev_pulse = ctrl_in_valid;
      prev_busy  = ctrl_busy;
    end
  end

  // ---------------- controller stand-in ----------------
  initial begin
    ctrl_busy = 0; ctrl_out_valid = 0; ctrl_rdata = '0;
    forever begin
      @(posedge clk); #1;
      ctrl_busy = (busy_mode == 1) ? 1'b1 : (busy_mode == 2) ? 1'($urandom % 2) : 1'b0;
      if (rd_active && rd_lat != 0 && cyc_n == rd_p + rd_lat) begin
        ctrl_out_valid = 1; ctrl_rdata = rd_val;
      end else if (noise_en && !rd_active && ($urandom % 4 == 0)) begin
        ctrl_out_valid = 1; ctrl_rdata = $urandom;
      end else begin
        ctrl_out_valid = 0; ctrl_rdata = $urandom;
      end
    end
  end

  // ---------------- master tasks ----------------
  task automatic wb_write(input logic [31:0] a, input logic [31:0] d, input int budget,
                          output int lat, output bit got);
    int s;
    @(posedge clk); #1;
    wb_cyc_i = 1; wb_stb_i = 1; wb_we_i = 1; wb_adr_i = a; wb_dat_i = d;
    s = cyc_n; got = 0; lat = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (wb_ack_o) begin got = 1; lat = cyc_n - s; break; end
    end
  endtask

  task automatic wb_read(input logic [31:0] a, input int lat_sel, input logic [31:0] val,
                         input int budget, output logic [31:0] data, output int ack_c,
                         output bit got);
    rd_lat = lat_sel; rd_val = val;
    @(posedge clk); #1;
    wb_cyc_i = 1; wb_stb_i = 1; wb_we_i = 0; wb_adr_i = a;
    got = 0; ack_c = -1; data = '0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (wb_ack_o) begin got = 1; ack_c = cyc_n; data = wb_dat_o; break; end
    end
  endtask

  task automatic bus_idle(input int n);
    @(posedge clk); #1;
    wb_cyc_i = 0; wb_stb_i = 0; wb_we_i = 0;
    repeat (n) @(posedge clk);
  endtask

  task automatic wait_drain(input int budget);
    bit ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !rd_active && !wr_pending) begin ok = 1; break; end
    end
    chk("queue drained in time", ok, 1);
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_rd_active(input int budget);
    bit ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (rd_active) begin ok = 1; break; end
    end
    chk("read issued in time", ok, 1);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, " wb_ack_o"}, wb_ack_o, 0);
    chk({tag, " wb_dat_o"}, wb_dat_o, 0);
    chk({tag, " ctrl_in_valid"}, ctrl_in_valid, 0);
    chk({tag, " ctrl_rw"}, ctrl_rw, 0);
    chk({tag, " ctrl_addr"}, ctrl_addr, 0);
    chk({tag, " ctrl_wdata"}, ctrl_wdata, 0);
    chk({tag, " rd_err"}, rd_err, 0);
    chk({tag, " wr_pending"}, wr_pending, 0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int          lat, ack_c, lat5, pc0, rst_c;
    bit          got;
    logic [31:0] data;
    logic [8:0]  hi;
    logic [31:0] a;

    wb_cyc_i = 0; wb_stb_i = 0; wb_we_i = 0; wb_sel_i = 4'hF; wb_adr_i = '0; wb_dat_i = '0;
    rst = 1;
    repeat (3) @(posedge clk); #1;
    check_zero("reset");
    rst = 0;
    repeat (2) @(posedge clk);

    // single posted write
    wb_write(32'h3800_0010, 32'h1234_5678, 20, lat, got);
    chk("single write acked", got, 1);
    chk("single write ack latency", lat, 1);
    ack_c = cyc_n;
    bus_idle(3);
    chk("single write pulse one cycle after ack", last_pulse_c - ack_c, 1);
    chk("single write ctrl_rw", ctrl_rw, 1);
    chk("single write ctrl_addr", ctrl_addr, 23'h10);
    chk("single write ctrl_wdata", ctrl_wdata, 32'h1234_5678);
    wait_drain(50);

    // five writes into a stalled controller
    busy_mode = 1;
    repeat (2) @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      wb_write(32'h3800_0100 + 32'(i * 4), 32'hA000_0000 + 32'(i), 20, lat, got);
      chk("fifo fill write ack latency", lat, 1);
    end
    chk("wr_pending with full fifo", wr_pending, 1);
    fork
      wb_write(32'h3800_0110, 32'hA000_0004, 100, lat5, got);
      begin repeat (10) @(posedge clk); #2 busy_mode = 0; end
    join
    chk("fifth write eventually acked", got, 1);
    chk("fifth write stalled past busy release", lat5 > 10, 1);
    bus_idle(0);
    wait_drain(100);
    chk("last issued write data", ctrl_wdata, 32'hA000_0004);

    // read behind two posted writes
    busy_mode = 1;
    repeat (2) @(posedge clk);
    wb_write(32'h3800_0200, 32'hB000_0001, 20, lat, got);
    wb_write(32'h3800_0204, 32'hB000_0002, 20, lat, got);
    fork
      wb_read(32'h3800_0010, 4, 32'hCAFE_F00D, 100, data, ack_c, got);
      begin repeat (6) @(posedge clk); #2 busy_mode = 0; end
    join
    chk("read behind writes acked", got, 1);
    chk("read data", data, 32'hCAFE_F00D);
    chk("read ack latency from pulse", ack_c - rd_p, 6);
    bus_idle(2);

    // timeout read, stickiness
    wb_read(32'h3800_0020, 0, 32'h0, 100, data, ack_c, got);
    chk("timeout read acked", got, 1);
    chk("timeout read data", data, 32'hDEAD_BEEF);
    chk("timeout read ack latency", ack_c - rd_p, T + 2);
    chk("rd_err after timeout", rd_err, 1);
    bus_idle(1);
    wb_read(32'h3800_0024, 3, 32'h5555_AAAA, 100, data, ack_c, got);
    chk("read after timeout data", data, 32'h5555_AAAA);
    chk("rd_err sticky", rd_err, 1);
    bus_idle(1);

    // latency right at the timeout edge, then one past it
    wb_read(32'h3800_0028, T, 32'h0BAD_F00D, 100, data, ack_c, got);
    chk("read at last wait cycle data", data, 32'h0BAD_F00D);
    chk("read at last wait cycle latency", ack_c - rd_p, T + 2);
    bus_idle(1);
    wb_read(32'h3800_002C, T + 1, 32'h1111_2222, 100, data, ack_c, got);
    chk("read one past timeout data", data, 32'hDEAD_BEEF);
    bus_idle(1);

    // unsolicited responses and out-of-window accesses
    noise_en = 1;
    pc0 = last_pulse_c;
    repeat (20) @(posedge clk);
    wb_write(32'h3000_0000, 32'h7777_7777, 10, lat, got);
    chk("out-of-window write not acked", got, 0);
    bus_idle(0);
    wb_read(32'h3000_0000, 2, 32'h0, 10, data, ack_c, got);
    chk("out-of-window read not acked", got, 0);
    bus_idle(2);
    chk("no request from noise or out-of-window", last_pulse_c, pc0);

    // master abandons a read while waiting for data
    rd_lat = 8; rd_val = 32'h9999_0000;
    @(posedge clk); #1;
    wb_cyc_i = 1; wb_stb_i = 1; wb_we_i = 0; wb_adr_i = 32'h3800_0300;
    wait_rd_active(50);
    repeat (3) @(posedge clk); #1;
    wb_cyc_i = 0; wb_stb_i = 0;
    repeat (12) @(posedge clk);
    chk("abandoned read finished", rd_active, 0);
    wb_write(32'h3800_0304, 32'h4444_0001, 20, lat, got);
    chk("write after abandoned read latency", lat, 1);
    bus_idle(0);
    wait_drain(50);

    // randomised traffic
    busy_mode = 2;
    for (int it = 0; it < 150; it++) begin
      a = {BASE[31:23], 23'($urandom) & 23'h7F_FFFC};
      if ($urandom % 10 == 0) begin
        hi = BASE[31:23] ^ 9'($urandom_range(1, 511));
        a[31:23] = hi;
        @(posedge clk); #1;
        wb_cyc_i = 1; wb_stb_i = 1; wb_we_i = 1'($urandom % 2); wb_adr_i = a; wb_dat_i = $urandom;
        repeat (3) @(posedge clk);
        bus_idle(0);
      end else if ($urandom % 10 < 6) begin
        wb_write(a, $urandom, 300, lat, got);
        chk("random write acked", got, 1);
      end else begin
        lat = ($urandom % 8 == 0) ? 0 : $urandom_range(1, T + 2);
        wb_read(a, lat, $urandom, 300, data, ack_c, got);
        chk("random read acked", got, 1);
        bus_idle(0);
      end
      if ($urandom % 3 == 0) bus_idle($urandom % 3);
    end
    bus_idle(0);
    busy_mode = 0;
    wait_drain(200);

    // reset while a read waits for data
    rd_lat = 0;
    @(posedge clk); #1;
    wb_cyc_i = 1; wb_stb_i = 1; wb_we_i = 0; wb_adr_i = 32'h3800_0400;
    wait_rd_active(50);
    repeat (3) @(posedge clk); #3;
    rst = 1;
    #1;
    check_zero("reset in read wait");
    wb_cyc_i = 0; wb_stb_i = 0;
    repeat (2) @(posedge clk); #1;
    rst = 0;
    repeat (T + 4) @(negedge clk);

    // reset with writes still buffered
    busy_mode = 1;
    repeat (2) @(posedge clk);
    for (int i = 0; i < 3; i++) wb_write(32'h3800_0500 + 32'(i * 4), 32'hC000_0000 + 32'(i), 20, lat, got);
    bus_idle(0);
    @(posedge clk); #3;
    rst = 1;
    #1;
    check_zero("reset with buffered writes");
    rst_c = cyc_n;
    busy_mode = 0;
    repeat (2) @(posedge clk); #1;
    rst = 0;
    repeat (6) @(negedge clk);
    chk("dropped writes not issued", last_pulse_c <= rst_c, 1);
    wb_write(32'h3800_0600, 32'hD00D_0001, 20, lat, got);
    chk("first write after reset latency", lat, 1);
    bus_idle(0);
    wait_drain(50);
    chk("first write after reset data", ctrl_wdata, 32'hD00D_0001);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

endmodule
